// File: rtl/axi_perf_seq.sv
// ---------------------------------------------------------------------------
// axi_perf_seq
// Single-master AXI4 traffic sequencer for DDR bandwidth measurement.
// A run writes an address-derived pattern over a range as INCR bursts. It then
// reads the same range back and compares every beat against the pattern.
// Only one transaction is outstanding at a time.
//
// Ports
//   clk, rst_n            : DDR UI clock, asynchronous active-low reset
//   start                 : one-cycle pulse, begins a run when idle
//   base_addr             : first byte address, aligned to one burst
//   burst_len             : AXI len (beats-1) used for every burst
//   num_bursts            : bursts per phase (0 gives an immediate done)
//   busy, done            : run in progress / one-cycle end-of-run pulse
//   wr_cycles, rd_cycles  : write-phase and read-phase cycle counts (saturating)
//   err_cnt               : response/data/rlast errors in the last run (saturating)
//   m_axi_*               : AXI4 master write (AW/W/B) and read (AR/R) channels
// ---------------------------------------------------------------------------
module axi_perf_seq #(
  parameter int AXI_ADDR_WIDTH = 28,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
  input  logic [7:0]                  burst_len,
  input  logic [15:0]                 num_bursts,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_WIDTH-1:0]        wr_cycles,
  output logic [CNT_WIDTH-1:0]        rd_cycles,
  output logic [15:0]                 err_cnt,
  // write address channel
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  // write data channel
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  // write response channel
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  // read address channel
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  // read data channel
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int LANES = AXI_DATA_WIDTH / 32;
  localparam logic [AXI_ID_WIDTH-1:0] ID_VAL = AXI_ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t                       r_state;
  logic                         r_busy;
  logic                         r_done;
  logic [CNT_WIDTH-1:0]         r_wrCycles;
  logic [CNT_WIDTH-1:0]         r_rdCycles;
  logic [15:0]                  r_errCnt;
  logic [AXI_ADDR_WIDTH-1:0]    r_base;
  logic [7:0]                   r_len;
  logic [15:0]                  r_numBursts;
  logic [15:0]                  r_burstCnt;
  logic [7:0]                   r_beat;
  logic [AXI_ADDR_WIDTH-1:0]    r_burstAddr;
  logic [AXI_ADDR_WIDTH-1:0]    r_beatAddr;
  logic                         r_awvalid;
  logic                         r_wvalid;
  logic [AXI_DATA_WIDTH-1:0]    r_wdata;
  logic                         r_wlast;
  logic                         r_bready;
  logic                         r_arvalid;
  logic                         r_rready;

  logic [AXI_ADDR_WIDTH-1:0]    w_step;
  logic [AXI_ADDR_WIDTH-1:0]    w_nextBeatAddr;
  logic                         w_lastBurst;
  logic                         w_finalBeat;
  logic                         w_nextIsLast;
  logic                         w_wFire;
  logic                         w_bFire;
  logic                         w_rFire;
  logic                         w_rBeatErr;
  logic                         w_rLastErr;
  logic [1:0]                   w_errInc;
  logic [16:0]                  w_errSum;
  logic [15:0]                  w_errNext;

  // Each 32-bit lane carries the beat's byte address, zero-extended.
  function automatic logic [AXI_DATA_WIDTH-1:0] patternOf(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_DATA_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[i*32 +: 32] = 32'(a);
    return p;
  endfunction

  // The burst stride is (len+1) beats of the full bus width; the address wraps modulo 2^AXI_ADDR_WIDTH.
  assign w_step         = AXI_ADDR_WIDTH'({1'b0, r_len} + 9'd1) << SIZE;
  assign w_nextBeatAddr = r_beatAddr + AXI_ADDR_WIDTH'(BYTES);
  assign w_lastBurst    = (r_burstCnt + 16'd1) == r_numBursts;
  assign w_finalBeat    = (r_beat == r_len);
  assign w_nextIsLast   = ({1'b0, r_beat} + 9'd1) == {1'b0, r_len};
  assign w_wFire        = r_wvalid & m_axi_wready;
  assign w_bFire        = r_bready & m_axi_bvalid;
  assign w_rFire        = r_rready & m_axi_rvalid;

  // A read beat with any combination of data, rresp or rid faults counts as a single beat error.
  // A misplaced or missing rlast counts as a separate error.
  assign w_rBeatErr = (m_axi_rdata != patternOf(r_beatAddr)) | (m_axi_rresp != 2'b00) |
                      (m_axi_rid != ID_VAL);
  assign w_rLastErr = (m_axi_rlast != w_finalBeat);

  always_comb begin
    w_errInc = 2'd0;
    if (r_state == S_B && w_bFire)
      w_errInc = {1'b0, m_axi_bresp != 2'b00} + {1'b0, m_axi_bid != ID_VAL};
    else if (r_state == S_R && w_rFire)
      w_errInc = {1'b0, w_rBeatErr} + {1'b0, w_rLastErr};
  end

  assign w_errSum  = {1'b0, r_errCnt} + {15'd0, w_errInc};
  assign w_errNext = w_errSum[16] ? 16'hFFFF : w_errSum[15:0];

  // Sequencer: one state machine owns every registered AXI output and the run statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wrCycles  <= '0;
      r_rdCycles  <= '0;
      r_errCnt    <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_numBursts <= '0;
      r_burstCnt  <= '0;
      r_beat      <= '0;
      r_burstAddr <= '0;
      r_beatAddr  <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_wlast     <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      r_errCnt <= w_errNext;
      if ((r_state == S_AW || r_state == S_W || r_state == S_B) && r_wrCycles != '1)
        r_wrCycles <= r_wrCycles + CNT_WIDTH'(1);
      if ((r_state == S_AR || r_state == S_R) && r_rdCycles != '1)
        r_rdCycles <= r_rdCycles + CNT_WIDTH'(1);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base      <= base_addr;
            r_len       <= burst_len;
            r_numBursts <= num_bursts;
            r_burstCnt  <= '0;
            r_burstAddr <= base_addr;
            r_wrCycles  <= '0;
            r_rdCycles  <= '0;
            r_errCnt    <= '0;
            if (num_bursts == 16'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy    <= 1'b1;
              r_awvalid <= 1'b1;
              r_state   <= S_AW;
            end
          end
        end

        S_AW: begin
          if (m_axi_awready) begin
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b1;
            r_wdata    <= patternOf(r_burstAddr);
            r_wlast    <= (r_len == 8'd0);
            r_beat     <= '0;
            r_beatAddr <= r_burstAddr;
            r_state    <= S_W;
          end
        end

        S_W: begin
          if (w_wFire) begin
            if (w_finalBeat) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_B;
            end else begin
              // The next beat is loaded on the same edge, so back-to-back beats have no bubble.
              r_beat     <= r_beat + 8'd1;
              r_beatAddr <= w_nextBeatAddr;
              r_wdata    <= patternOf(w_nextBeatAddr);
              r_wlast    <= w_nextIsLast;
            end
          end
        end

        S_B: begin
          if (m_axi_bvalid) begin
            r_bready <= 1'b0;
            if (w_lastBurst) begin
              r_burstCnt  <= '0;
              r_burstAddr <= r_base;
              r_arvalid   <= 1'b1;
              r_state     <= S_AR;
            end else begin
              r_burstCnt  <= r_burstCnt + 16'd1;
              r_burstAddr <= r_burstAddr + w_step;
              r_awvalid   <= 1'b1;
              r_state     <= S_AW;
            end
          end
        end

        S_AR: begin
          if (m_axi_arready) begin
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b1;
            r_beat     <= '0;
            r_beatAddr <= r_burstAddr;
            r_state    <= S_R;
          end
        end

        S_R: begin
          if (m_axi_rvalid) begin
            // A burst ends on whichever comes first: rlast or the expected final beat.
            if (m_axi_rlast || w_finalBeat) begin
              r_rready <= 1'b0;
              if (w_lastBurst) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_burstCnt  <= r_burstCnt + 16'd1;
                r_burstAddr <= r_burstAddr + w_step;
                r_arvalid   <= 1'b1;
                r_state     <= S_AR;
              end
            end else begin
              r_beat     <= r_beat + 8'd1;
              r_beatAddr <= w_nextBeatAddr;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign wr_cycles     = r_wrCycles;
  assign rd_cycles     = r_rdCycles;
  assign err_cnt       = r_errCnt;

  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_burstAddr;
  assign m_axi_awid    = ID_VAL;
  assign m_axi_awlen   = r_len;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;

  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = r_wlast;

  assign m_axi_bready  = r_bready;

  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_burstAddr;
  assign m_axi_arid    = ID_VAL;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;

  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_perf_seq.sv
// ---------------------------------------------------------------------------
// tb_axi_perf_seq
// Directed and randomized bench for axi_perf_seq. The bench contains an AXI
// slave with optional random backpressure and fault injection. Expected
// addresses, data, error totals and phase cycle counts come from address
// arithmetic and from the observed AXI handshakes.
// ---------------------------------------------------------------------------
module tb_axi_perf_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [27:0]  base_addr;
  logic [7:0]   burst_len;
  logic [15:0]  num_bursts;
  logic         busy, done;
  logic [31:0]  wr_cycles, rd_cycles;
  logic [15:0]  err_cnt;
  logic         m_axi_awvalid, m_axi_awready = 1'b0;
  logic [27:0]  m_axi_awaddr;
  logic [3:0]   m_axi_awid;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_wvalid, m_axi_wready = 1'b0;
  logic [127:0] m_axi_wdata;
  logic [15:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_bvalid = 1'b0, m_axi_bready;
  logic [3:0]   m_axi_bid = '0;
  logic [1:0]   m_axi_bresp = '0;
  logic         m_axi_arvalid, m_axi_arready = 1'b0;
  logic [27:0]  m_axi_araddr;
  logic [3:0]   m_axi_arid;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_rvalid = 1'b0, m_axi_rready;
  logic [3:0]   m_axi_rid = '0;
  logic [127:0] m_axi_rdata = '0;
  logic [1:0]   m_axi_rresp = '0;
  logic         m_axi_rlast = 1'b0;

  always #5 clk = ~clk;

  axi_perf_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .num_bursts(num_bursts), .busy(busy), .done(done),
    .wr_cycles(wr_cycles), .rd_cycles(rd_cycles), .err_cnt(err_cnt),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  int compared = 0;
  int mismatched = 0;

  // run configuration and fault plan
  logic [27:0] cfgBase;
  int cfgLen, cfgNb;
  bit bpOn;
  int faultFlipBurst = -1, faultFlipBeat = -1;
  int faultBrespBurst = -1;
  int faultEarlyBurst = -1, faultEarlyBeat = -1;

  // run observations
  int cyc = 0;
  int awCount, wBeatCount, bCount, arCount, rBurstDone, doneCount, validSeen, expErr;
  int tFirstAw, tLastB, tFirstAr, tLastR;

  // slave state
  int bPending, rQueued, rBeat;
  bit rActive, bFire, rFire;
  logic pAw, pW, pAr;
  logic [27:0] pAwAddr, pArAddr;
  logic [127:0] pWData;
  logic pWLast;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] patternOf(input logic [27:0] a);
    logic [127:0] p;
    for (int i = 0; i < 4; i++) p[i*32 +: 32] = {4'h0, a};
    return p;
  endfunction

  function automatic logic [27:0] burstAddr(input int k);
    return cfgBase + 28'(k * (cfgLen + 1) * 16);
  endfunction

  function automatic logic [27:0] beatAddr(input int k, input int j);
    return burstAddr(k) + 28'(j * 16);
  endfunction

  task automatic clearStats();
    awCount = 0; wBeatCount = 0; bCount = 0; arCount = 0; rBurstDone = 0;
    doneCount = 0; validSeen = 0; expErr = 0;
    tFirstAw = -1; tLastB = -1; tFirstAr = -1; tLastR = -1;
  endtask

  // Slave model and protocol monitor. It samples on the falling edge and
  // drives the values that the DUT sees at the next rising edge.
  always @(negedge clk) begin
    bit early;
    int k, j;
    cyc++;
    if (!rst_n) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
      bFire = 0; rFire = 0; bPending = 0; rQueued = 0; rActive = 0;
      pAw = 0; pW = 0; pAr = 0;
    end else begin
      if (pAw) begin
        checkOutput("awvalid_hold", 128'(m_axi_awvalid), 1);
        checkOutput("awaddr_hold", 128'(m_axi_awaddr), 128'(pAwAddr));
      end
      if (pW) begin
        checkOutput("wvalid_hold", 128'(m_axi_wvalid), 1);
        checkOutput("wdata_hold", m_axi_wdata, pWData);
        checkOutput("wlast_hold", 128'(m_axi_wlast), 128'(pWLast));
      end
      if (pAr) begin
        checkOutput("arvalid_hold", 128'(m_axi_arvalid), 1);
        checkOutput("araddr_hold", 128'(m_axi_araddr), 128'(pArAddr));
      end
      if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) validSeen++;
      if (done) doneCount++;
      if (m_axi_awvalid && tFirstAw < 0) tFirstAw = cyc;
      if (m_axi_arvalid && tFirstAr < 0) tFirstAr = cyc;

      // retire transfers completed at the last rising edge
      if (bFire) m_axi_bvalid = 0;
      if (rFire) begin
        early = (rBurstDone == faultEarlyBurst) && (rBeat == faultEarlyBeat);
        m_axi_rvalid = 0; m_axi_rlast = 0;
        if (rBeat == cfgLen || early) begin
          rActive = 0;
          rBurstDone++;
        end else rBeat++;
      end

      // write response, issued the cycle after the last W beat
      if (!m_axi_bvalid && bPending > 0) begin
        m_axi_bvalid = 1;
        m_axi_bid = '0;
        m_axi_bresp = (bCount == faultBrespBurst) ? 2'b10 : 2'b00;
        if (bCount == faultBrespBurst) expErr++;
        bPending--;
        bCount++;
      end

      // read data, one burst at a time in AR order
      if (!rActive && rQueued > 0) begin
        rActive = 1; rQueued--; rBeat = 0;
      end
      if (rActive && !m_axi_rvalid) begin
        m_axi_rvalid = bpOn ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_axi_rvalid) begin
          early = (rBurstDone == faultEarlyBurst) && (rBeat == faultEarlyBeat);
          m_axi_rdata = patternOf(beatAddr(rBurstDone, rBeat));
          if (rBurstDone == faultFlipBurst && rBeat == faultFlipBeat) begin
            m_axi_rdata[5] = ~m_axi_rdata[5];
            expErr++;
          end
          m_axi_rlast = (rBeat == cfgLen) || early;
          if (early) expErr++;
          m_axi_rresp = 2'b00;
          m_axi_rid = '0;
        end
      end

      m_axi_awready = bpOn ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = bpOn ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_arready = bpOn ? 1'($urandom_range(0, 1)) : 1'b1;

      if (m_axi_awvalid && m_axi_awready) begin
        checkOutput("awaddr", 128'(m_axi_awaddr), 128'(burstAddr(awCount)));
        checkOutput("awlen", 128'(m_axi_awlen), 128'(cfgLen));
        checkOutput("awsize", 128'(m_axi_awsize), 4);
        checkOutput("awburst", 128'(m_axi_awburst), 1);
        checkOutput("awid", 128'(m_axi_awid), 0);
        awCount++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        k = wBeatCount / (cfgLen + 1);
        j = wBeatCount % (cfgLen + 1);
        checkOutput("wdata", m_axi_wdata, patternOf(beatAddr(k, j)));
        checkOutput("wlast", 128'(m_axi_wlast), 128'(j == cfgLen));
        checkOutput("wstrb", 128'(m_axi_wstrb), 128'hFFFF);
        wBeatCount++;
        if (j == cfgLen) bPending++;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        checkOutput("araddr", 128'(m_axi_araddr), 128'(burstAddr(arCount)));
        checkOutput("arlen", 128'(m_axi_arlen), 128'(cfgLen));
        checkOutput("arsize", 128'(m_axi_arsize), 4);
        checkOutput("arid", 128'(m_axi_arid), 0);
        arCount++;
        rQueued++;
      end

      bFire = m_axi_bvalid && m_axi_bready;
      if (bFire) tLastB = cyc;
      rFire = m_axi_rvalid && m_axi_rready;
      if (rFire) tLastR = cyc;

      pAw = m_axi_awvalid && !m_axi_awready; pAwAddr = m_axi_awaddr;
      pW  = m_axi_wvalid && !m_axi_wready;   pWData = m_axi_wdata; pWLast = m_axi_wlast;
      pAr = m_axi_arvalid && !m_axi_arready; pArAddr = m_axi_araddr;
    end
  end

  // Pulses start for one cycle; it is called and returns just after a falling edge.
  task automatic applyStimulus(input logic [27:0] base, input int len, input int nb);
    base_addr  = base;
    burst_len  = 8'(len);
    num_bursts = 16'(nb);
    start      = 1'b1;
    @(negedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input logic [27:0] base, input int len,
                             input int nb, input bit bp, input bit pulseMid);
    cfgBase = base; cfgLen = len; cfgNb = nb; bpOn = bp;
    clearStats();
    applyStimulus(base, len, nb);
    checkOutput({name, "_busy_start"}, 128'(busy), 1);
    if (pulseMid) begin
      repeat (20) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 4000 && doneCount == 0; i++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput({name, "_done_count"}, 128'(doneCount), 1);
    checkOutput({name, "_busy_end"}, 128'(busy), 0);
    checkOutput({name, "_err_cnt"}, 128'(err_cnt), 128'(expErr));
    checkOutput({name, "_wr_cycles"}, 128'(wr_cycles), 128'(tLastB - tFirstAw + 1));
    checkOutput({name, "_rd_cycles"}, 128'(rd_cycles), 128'(tLastR - tFirstAr + 1));
    checkOutput({name, "_aw_count"}, 128'(awCount), 128'(nb));
    checkOutput({name, "_w_beats"}, 128'(wBeatCount), 128'(nb * (len + 1)));
    checkOutput({name, "_ar_count"}, 128'(arCount), 128'(nb));
    checkOutput({name, "_r_bursts"}, 128'(rBurstDone), 128'(nb));
    faultFlipBurst = -1; faultFlipBeat = -1; faultBrespBurst = -1;
    faultEarlyBurst = -1; faultEarlyBeat = -1;
  endtask

  initial begin
    logic [27:0] rb;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; burst_len = '0; num_bursts = '0;
    cfgBase = '0; cfgLen = 0; cfgNb = 0; bpOn = 0;
    clearStats();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 128'(busy), 0);
    checkOutput("rst_done", 128'(done), 0);
    checkOutput("rst_valids", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 0);
    checkOutput("rst_readies", 128'({m_axi_bready, m_axi_rready}), 0);
    checkOutput("rst_err", 128'(err_cnt), 0);
    checkOutput("rst_cycles", 128'({wr_cycles, rd_cycles}), 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // ideal slave, 4 bursts of 8 beats from 0x0
    runAndCheck("ideal", 28'h0, 7, 4, 0, 0);

    // one flipped read bit in beat 3 of read burst 2
    faultFlipBurst = 2; faultFlipBeat = 3;
    runAndCheck("flip", 28'h0, 7, 4, 0, 0);

    // random backpressure from a random aligned base
    rb = 28'($urandom) & ~28'hFF;
    runAndCheck("backpressure", rb, 15, 8, 1, 0);

    // address wraps past the top of the address space
    runAndCheck("wrap", 28'hFFFFF00, 15, 4, 1, 0);

    // SLVERR on write burst 1 and early rlast on beat 5 of read burst 0
    faultBrespBurst = 1; faultEarlyBurst = 0; faultEarlyBeat = 5;
    runAndCheck("faults", 28'h1000, 7, 4, 0, 0);

    // zero bursts gives a done pulse on the next cycle without AXI traffic
    cfgNb = 0; bpOn = 0;
    clearStats();
    applyStimulus(28'h0, 7, 0);
    checkOutput("zero_done_high", 128'(done), 1);
    checkOutput("zero_busy", 128'(busy), 0);
    @(negedge clk); #1;
    checkOutput("zero_done_low", 128'(done), 0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("zero_done_count", 128'(doneCount), 1);
    checkOutput("zero_no_valids", 128'(validSeen), 0);
    checkOutput("zero_cycles", 128'({wr_cycles, rd_cycles}), 0);

    // start pulsed again while the run is busy is ignored
    runAndCheck("busy_start", 28'h200, 7, 4, 0, 1);

    // asynchronous reset during the W phase of the first burst
    cfgBase = 28'h400; cfgLen = 7; cfgNb = 4; bpOn = 0;
    clearStats();
    applyStimulus(28'h400, 7, 4);
    for (int i = 0; i < 200 && wBeatCount < 3; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("rst_mid_beats", 128'(wBeatCount), 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valids", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 0);
    checkOutput("rst_mid_readies", 128'({m_axi_bready, m_axi_rready}), 0);
    checkOutput("rst_mid_busy", 128'(busy), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    runAndCheck("after_rst", 28'h400, 7, 4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_perf_seq.md
Name: axi_perf_seq

Overview:
- Single-master AXI4 traffic sequencer driving the DDR controller's AXI slave port for bandwidth measurement.
- On `start` it writes a deterministic pattern over an address range as INCR bursts, then reads the range back and checks it.
- Reports write-phase cycles, read-phase cycles and an error count to the UART command/report logic in the same clock domain.
- One transaction outstanding at a time.

Parameters:
- AXI_ADDR_WIDTH, 28, byte address width
- AXI_DATA_WIDTH, 128, data bus width; must be a multiple of 32
- AXI_ID_WIDTH, 4, ID width
- AXI_ID, 0, ID driven on awid/arid; bid/rid must match it
- CNT_WIDTH, 32, width of cycle counters

Ports:
- clk  in  1  clock (DDR UI clock)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a run when idle
- base_addr  in  AXI_ADDR_WIDTH  first byte address; aligned to one burst size
- burst_len  in  8  AXI len (beats-1) for every burst
- num_bursts  in  16  bursts per phase
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- wr_cycles  out  CNT_WIDTH  cycles from first awvalid to last bvalid&bready
- rd_cycles  out  CNT_WIDTH  cycles from first arvalid to last rlast beat
- err_cnt  out  16  errors in last run, saturating
- m_axi_aw{valid,addr,id,len,size,burst}/awready, m_axi_w{valid,data,strb,last}/wready, m_axi_b{valid,id,resp}/bready: AXI4 write channels, standard widths
- m_axi_ar{valid,addr,id,len,size,burst}/arready, m_axi_r{valid,id,data,resp,last}/rready: AXI4 read channels, standard widths

Behaviour:
- Reset (async assert, sync release): state IDLE; all valids 0; bready/rready 0; busy 0; done 0; counters and err_cnt 0.
- States and transitions:
  - IDLE -> AW on start (num_bursts!=0); latch base_addr, burst_len, num_bursts; clear counters and err_cnt; busy=1.
  - AW: awvalid=1 until awready; -> W.
  - W: stream burst_len+1 beats; wlast on final beat; -> B.
  - B: bready=1; on bvalid -> AW if bursts remain, else reset address to base and -> AR.
  - AR: arvalid=1 until arready; -> R.
  - R: rready=1; on rlast beat -> AR if bursts remain, else -> DONE.
  - DONE: done=1 for one cycle, busy=0; -> IDLE.
- start with num_bursts==0: done pulse the next cycle; counters 0.
- start while busy: ignored.
- Fixed fields: awsize/arsize = log2(AXI_DATA_WIDTH/8); burst=INCR; wstrb all ones.
- Address step per burst: (burst_len+1)*(AXI_DATA_WIDTH/8), modulo 2^AXI_ADDR_WIDTH (wraps silently). Bursts are not split at 4 KB; callers keep burst bytes a power of two ≤4096 with aligned base.
- Data pattern: beat byte address A (32-bit, zero-extended) replicated AXI_DATA_WIDTH/32 times.
- Valid/data stability: valid and payload are held stable until ready. Valid never depends combinationally on ready. Zero-bubble back-to-back beats when wready=1.
- err_cnt increments by 1 per event, saturating at 0xFFFF:
  - bresp!=OKAY
  - bid!=AXI_ID
  - R beat with data mismatch, rresp!=OKAY, or rid!=AXI_ID (one increment per beat even with multiple faults)
  - rlast asserted on a non-final beat, or absent on the final beat
- Missing rlast: the burst still ends after burst_len+1 beats.
- Early rlast: the burst ends on rlast, and an error is counted.
- wr_cycles increments every cycle in AW/W/B; rd_cycles every cycle in AR/R. Both saturate at all-ones and hold until the next start.
- Reset mid-run: outputs drop immediately. No attempt to complete AXI transactions (the slave is reset by the same rst_n).

Test Plan:
- Base 0x0, len=7, num_bursts=4, ideal slave model (always ready, 1-cycle latency) -> awaddr 0x000, 0x080, 0x100, 0x180; 32 W beats; done once; err_cnt=0; wr_cycles, rd_cycles match model count.
- Same run, slave flips bit 5 of beat 3 of read burst 2 -> err_cnt=1; all 4 read bursts still complete.
- Random wready/arready/rvalid backpressure (50%), len=15, num_bursts=8 -> no valid drops or payload changes while stalled; err_cnt=0.
- bresp=SLVERR on burst 1, and rlast early on beat 5 of a len=7 read -> err_cnt=2; state returns to IDLE.
- num_bursts=0 -> done exactly 1 cycle after start, no AXI valids; start pulsed while busy -> ignored, single done.
- rst_n low during W phase, beat 3 -> all valids 0 asynchronously, busy=0; new start after release runs cleanly.
